// File: rtl/fft8_unload_if.sv
// Bundle between the FFT8 result port, the serial bin stream and the status flags.
// The outMag signal exists only when FFT8_UNLOAD_MAG_EN is defined.
interface fft8_unload_if #(
    parameter int W = 16
);
    logic         resultValid;
    logic [W-1:0] y  [0:7];
    logic [W-1:0] yi [0:7];
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outRe;
    logic [W-1:0] outIm;
    logic [2:0]   outIdx;
    logic         outLast;
    logic         frameDropped;
    logic         busy;
`ifdef FFT8_UNLOAD_MAG_EN
    logic [W-1:0] outMag;
`endif

    modport slave (
        input  resultValid, y, yi, outReady,
        output outValid, outRe, outIm, outIdx, outLast, frameDropped, busy
`ifdef FFT8_UNLOAD_MAG_EN
        , output outMag
`endif
    );

    modport master (
        output resultValid, y, yi, outReady,
        input  outValid, outRe, outIm, outIdx, outLast, frameDropped, busy
`ifdef FFT8_UNLOAD_MAG_EN
        , input outMag
`endif
    );
endinterface

// File: rtl/fft8_unload.sv
// Double-buffered FFT8 frame capture, streamed out one bin per cycle over valid/ready.
// Define FFT8_UNLOAD_MAG_EN to add the outMag magnitude estimate.
//
// state | meaning
// IDLE  | no frame being drained, outValid low
// DRAIN | presenting bins of buffer rsel, outValid high
module fft8_unload #(
    parameter int INT_BITS  = 8,
    parameter int FRAC_BITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fft8_unload_if.slave  bus
);
    localparam int W = INT_BITS + FRAC_BITS;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t       state_q;
    logic [W-1:0] buf_re_q [2][8];
    logic [W-1:0] buf_im_q [2][8];
    logic [1:0]   full_q;
    logic         wsel_q;
    logic         rsel_q;
    logic [2:0]   idx_q;
    logic         valid_q;
    logic         last_q;
    logic         drop_q;
    logic [W-1:0] re_q;
    logic [W-1:0] im_q;
    logic         capture;
    logic         other_sel;

    assign capture   = bus.resultValid && !full_q[wsel_q];
    assign other_sel = ~rsel_q;

    // Frame storage needs no reset: full_q alone decides whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 8; i++) begin
                buf_re_q[wsel_q][i] <= bus.y[i];
                buf_im_q[wsel_q][i] <= bus.yi[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            full_q  <= 2'b00;
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            drop_q <= 1'b0;
            if (bus.resultValid) begin
                if (!full_q[wsel_q]) begin
                    full_q[wsel_q] <= 1'b1;
                    wsel_q         <= ~wsel_q;
                end else begin
                    drop_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (full_q[rsel_q]) begin
                        state_q <= DRAIN;
                        valid_q <= 1'b1;
                        idx_q   <= 3'd0;
                        last_q  <= 1'b0;
                        re_q    <= buf_re_q[rsel_q][0];
                        im_q    <= buf_im_q[rsel_q][0];
                    end
                end
                DRAIN: begin
                    if (bus.outReady) begin
                        if (idx_q == 3'd7) begin
                            // A freed buffer cannot be the capture target this edge, so no set/clear clash.
                            full_q[rsel_q] <= 1'b0;
                            rsel_q         <= other_sel;
                            idx_q          <= 3'd0;
                            last_q         <= 1'b0;
                            if (full_q[other_sel]) begin
                                re_q <= buf_re_q[other_sel][0];
                                im_q <= buf_im_q[other_sel][0];
                            end else begin
                                state_q <= IDLE;
                                valid_q <= 1'b0;
                            end
                        end else begin
                            idx_q  <= idx_q + 3'd1;
                            last_q <= (idx_q == 3'd6);
                            re_q   <= buf_re_q[rsel_q][idx_q + 3'd1];
                            im_q   <= buf_im_q[rsel_q][idx_q + 3'd1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.outValid     = valid_q;
    assign bus.outRe        = re_q;
    assign bus.outIm        = im_q;
    assign bus.outIdx       = idx_q;
    assign bus.outLast      = last_q;
    assign bus.frameDropped = drop_q;
    assign bus.busy         = full_q[0] | full_q[1];

`ifdef FFT8_UNLOAD_MAG_EN
    logic [W:0]   ext_re, ext_im, abs_re, abs_im, mag_max, mag_min;
    logic [W+1:0] mag_sum;

    // Derived from the registered bin, so it holds exactly when outRe/outIm hold.
    always_comb begin
        ext_re  = {re_q[W-1], re_q};
        ext_im  = {im_q[W-1], im_q};
        abs_re  = ext_re[W] ? (~ext_re + {{W{1'b0}}, 1'b1}) : ext_re;
        abs_im  = ext_im[W] ? (~ext_im + {{W{1'b0}}, 1'b1}) : ext_im;
        mag_max = (abs_re > abs_im) ? abs_re : abs_im;
        mag_min = (abs_re > abs_im) ? abs_im : abs_re;
        mag_sum = {1'b0, mag_max} + {1'b0, (mag_min >> 1)};
    end

    assign bus.outMag = (mag_sum > {3'b000, {(W-1){1'b1}}}) ? {1'b0, {(W-1){1'b1}}}
                                                            : mag_sum[W-1:0];
`endif
endmodule

// File: tb/tb_fft8_unload.sv
// Scoreboard bench for fft8_unload: frames expected to be captured are queued bin by bin
// and popped on each output handshake; FFT8_UNLOAD_MAG_EN also enables magnitude checks.
module tb_fft8_unload;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [2:0]   idx;
        logic         last;
    } bin_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   hs_count = 0;
    bin_t exp_q[$];
    logic [W-1:0] f_re [8];
    logic [W-1:0] f_im [8];

    bit           stalled = 1'b0;
    logic [W-1:0] held_re, held_im;
    logic [2:0]   held_idx;
    logic         held_last;

    fft8_unload_if #(.W(W)) bus ();

    fft8_unload #(.INT_BITS(8), .FRAC_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mag_model(input logic [W-1:0] re, input logic [W-1:0] im);
        int a, b, m;
        a = $signed(re);
        b = $signed(im);
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        m = (a > b) ? a + b / 2 : b + a / 2;
        if (m > 32767) m = 32767;
        return m[W-1:0];
    endfunction

    task automatic push_frame();
        for (int i = 0; i < 8; i++) begin
            bin_t e;
            e.re = f_re[i];
            e.im = f_im[i];
            e.idx = 3'(i);
            e.last = (i == 7);
            exp_q.push_back(e);
        end
    endtask

    task automatic put_frame();
        for (int i = 0; i < 8; i++) begin
            bus.y[i]  = f_re[i];
            bus.yi[i] = f_im[i];
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) begin
            f_re[i] = W'($urandom);
            f_im[i] = W'($urandom);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Handshake at the coming edge is judged on the falling edge before it.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", bus.outValid, 1);
                check("hold_re", bus.outRe, held_re);
                check("hold_im", bus.outIm, held_im);
                check("hold_idx", bus.outIdx, held_idx);
                check("hold_last", bus.outLast, held_last);
            end
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bin", 1, 0);
                end else begin
                    bin_t e;
                    e = exp_q.pop_front();
                    check("bin_re", bus.outRe, e.re);
                    check("bin_im", bus.outIm, e.im);
                    check("bin_idx", bus.outIdx, e.idx);
                    check("bin_last", bus.outLast, e.last);
`ifdef FFT8_UNLOAD_MAG_EN
                    check("bin_mag", bus.outMag, mag_model(e.re, e.im));
`endif
                end
                hs_count++;
            end
            stalled   = bus.outValid && !bus.outReady;
            held_re   = bus.outRe;
            held_im   = bus.outIm;
            held_idx  = bus.outIdx;
            held_last = bus.outLast;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus.resultValid = 1'b0;
        bus.outReady    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.y[i]  = '0;
            bus.yi[i] = '0;
        end

        // Reset state
        #12;
        check("rst_valid", bus.outValid, 0);
        check("rst_last", bus.outLast, 0);
        check("rst_drop", bus.frameDropped, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_re", bus.outRe, 0);
        check("rst_im", bus.outIm, 0);
        check("rst_idx", bus.outIdx, 0);
`ifdef FFT8_UNLOAD_MAG_EN
        check("rst_mag", bus.outMag, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame: FFT of 1..8 in Q8.8
        f_re = '{16'h2400, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
        f_im = '{16'h0000, 16'h09A8, 16'h0400, 16'h01A8, 16'h0000, 16'hFE58, 16'hFC00, 16'hF658};
        push_frame();
        @(posedge clk); #1;
        put_frame();
        bus.resultValid = 1'b1;
        @(posedge clk); #1;
        bus.resultValid = 1'b0;
        check("lat_edge_n", bus.outValid, 0);
        @(posedge clk); #1;
        check("lat_valid", bus.outValid, 1);
        check("lat_idx0", bus.outIdx, 0);
        check("bin0_re", bus.outRe, 16'h2400);
        check("bin0_im", bus.outIm, 16'h0000);
        check("busy_1", bus.busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bin2_idx", bus.outIdx, 2);
        check("bin2_re", bus.outRe, 16'hFC00);
        check("bin2_im", bus.outIm, 16'h0400);
`ifdef FFT8_UNLOAD_MAG_EN
        check("bin2_mag", bus.outMag, 16'h0600);
`endif
        wait_drain(40);
        @(posedge clk); #1;
        check("idle_valid", bus.outValid, 0);
        check("idle_busy", bus.busy, 0);

        // Backpressure
        rand_frame();
        push_frame();
        put_frame();
        start = hs_count;
        bus.resultValid = 1'b1;
        @(posedge clk); #1;
        bus.resultValid = 1'b0;
        for (int k = 0; k < 60 && hs_count < start + 8; k++) begin
            bus.outReady = pat[k % 4];
            @(posedge clk); #1;
        end
        bus.outReady = 1'b1;
        check("bp_handshakes", hs_count - start, 8);
        check("bp_queue", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check("bp_idle", bus.outValid, 0);

        // Back-to-back frames
        rand_frame();
        push_frame();
        put_frame();
        bus.resultValid = 1'b1;
        @(posedge clk); #1;
        rand_frame();
        push_frame();
        put_frame();
        @(posedge clk); #1;
        bus.resultValid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("b2b_valid", bus.outValid, 1);
            @(posedge clk); #1;
        end
        check("b2b_end", bus.outValid, 0);
        check("b2b_queue", exp_q.size(), 0);

        // Overflow: third frame dropped
        bus.outReady = 1'b0;
        rand_frame();
        push_frame();
        put_frame();
        bus.resultValid = 1'b1;
        @(posedge clk); #1;
        check("ovf_drop0", bus.frameDropped, 0);
        rand_frame();
        push_frame();
        put_frame();
        @(posedge clk); #1;
        check("ovf_drop1", bus.frameDropped, 0);
        rand_frame();
        put_frame();
        @(posedge clk); #1;
        bus.resultValid = 1'b0;
        check("ovf_drop2", bus.frameDropped, 1);
        @(posedge clk); #1;
        check("ovf_drop_pulse", bus.frameDropped, 0);
        check("ovf_busy", bus.busy, 1);
        bus.outReady = 1'b1;
        wait_drain(60);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_idle", bus.outValid, 0);
        check("ovf_busy_end", bus.busy, 0);

        // Reset mid-drain after 3 bins
        rand_frame();
        push_frame();
        put_frame();
        start = hs_count;
        bus.resultValid = 1'b1;
        @(posedge clk); #1;
        bus.resultValid = 1'b0;
        for (int k = 0; k < 20 && hs_count < start + 3; k++) @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", bus.outValid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_idx", bus.outIdx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rand_frame();
`ifdef FFT8_UNLOAD_MAG_EN
        f_re[0] = 16'h7F00;
        f_im[0] = 16'h7F00;
`endif
        push_frame();
        put_frame();
        @(posedge clk); #1;
        bus.resultValid = 1'b1;
        @(posedge clk); #1;
        bus.resultValid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", bus.outValid, 1);
        check("post_rst_idx", bus.outIdx, 0);
`ifdef FFT8_UNLOAD_MAG_EN
        check("mag_sat", bus.outMag, 16'h7FFF);
`endif
        wait_drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft8_unload.md
# fft8_unload

Result-side consumer for the 8-point FFT core: it captures each parallel complex frame the FFT presents with `resultValid` and streams it out one bin per cycle, in natural order, over a valid/ready handshake. Two frame buffers let the FFT deliver a new frame while the previous one drains. The block sits between the FFT8 output bundle (`y[0:7]`, `yi[0:7]`, `resultValid`) and any serial downstream consumer.

## Interface
- `INT_BITS`, default 8: integer bits of each Q-format sample, sign included.
- `FRAC_BITS`, default 8: fractional bits. Sample width is W = INT_BITS + FRAC_BITS (16 by default, `[7:-8]` layout).

Ports:
- `clk`  in  1  the single clock; every register samples on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `resultValid`  in  1  the FFT frame on `y`/`yi` is valid this cycle.
- `y[0:7]`  in  8×W  real parts of bins 0..7, signed fixed point.
- `yi[0:7]`  in  8×W  imaginary parts of bins 0..7, signed fixed point.
- `outValid`  out  1  `outRe`, `outIm`, `outIdx` and `outLast` are valid.
- `outReady`  in  1  downstream accepts the current bin.
- `outRe`  out  W  real part of the current bin.
- `outIm`  out  W  imaginary part of the current bin.
- `outIdx`  out  3  bin index, 0..7.
- `outLast`  out  1  high together with bin 7.
- `frameDropped`  out  1  one-cycle pulse when an incoming frame is discarded.
- `busy`  out  1  at least one buffer holds data.
- `outMag`  out  W  magnitude estimate; present only when `FFT8_UNLOAD_MAG_EN` is defined.

## Operation
- Storage: two frame buffers, B0 and B1. Each buffer has a registered `full` flag. A write pointer `wsel` selects the buffer that receives the next frame. A read pointer `rsel` selects the buffer being drained. Reset state: `wsel = rsel = 0`, both flags 0, bin counter 0.
- Capture:
  - Condition: `resultValid` = 1 and `full[wsel]` = 0 at the clock edge.
  - Action: all 16 words are stored in B[wsel], `full[wsel]` is set, and `wsel` toggles.
  - If `full[wsel]` = 1 instead, the frame is discarded and `frameDropped` pulses for 1 cycle.
- Drain FSM:
  - IDLE: `outValid` = 0. Moves to DRAIN on the cycle after `full[rsel]` becomes 1.
  - DRAIN: `outValid` = 1. Outputs come from B[rsel] at the bin-counter position.
  - Each cycle with `outValid && outReady`, the bin counter increments.
  - On the handshake of bin 7: clear `full[rsel]`, toggle `rsel`, reset the counter to 0. If the other buffer is full, stay in DRAIN with no bubble; otherwise go to IDLE.
- Output stability: while `outValid` = 1 and `outReady` = 0, all outputs hold.
- Values are passed through bit-exact. No scaling, rounding or reordering is applied.
- `busy` = `full[0] | full[1]`.

## Timing
- Reset values: `outValid`, `outLast`, `frameDropped`, `busy` = 0; `outRe`, `outIm`, `outIdx` = 0; `outMag` = 0.
- Latency: with a free buffer and the drain idle, `resultValid` at edge N gives `outValid` = 1 with bin 0 after edge N+1.
- Throughput: with `outReady` held at 1, 8 bins take 8 consecutive cycles. Back-to-back frames stream with no gap.
- Free/capture collision: a buffer freed by the bin-7 handshake at edge N accepts a capture from edge N+1 onward. If `resultValid` arrives at edge N while both buffers are full, that frame is dropped.
- `outReady` may toggle freely. Only cycles where both `outValid` and `outReady` are high advance the counter.
- Reset mid-operation: both buffers empty immediately, the partial frame is lost, and the FSM returns to IDLE.

## Configuration
- Macro: `FFT8_UNLOAD_MAG_EN`.
- Defined:
  - `outMag` port and logic are present: `outMag = max(|re|,|im|) + min(|re|,|im|)/2`.
  - Absolute values are taken in W+1 bits; the `/2` is an arithmetic shift right, truncating.
  - The result saturates to the maximum positive W-bit value.
  - `outMag` is valid and held under the same rules as `outRe`.
- Undefined: the port is absent and no magnitude logic is built. All other behaviour is identical.

## Test plan
- Single frame (FFT of inputs 1..8), `outReady` = 1:
  - bins appear 1 cycle after `resultValid`, idx 0..7, `outLast` only on idx 7;
  - bin 0 = 16'h2400 + j16'h0000;
  - bin 2 = 16'hFC00 + j16'h0400 (-4 + j4).
- Backpressure: `outReady` toggling 1,0,0,1,… → each bin held stable while stalled, no bin skipped or repeated, 8 handshakes total.
- Back-to-back frames: `resultValid` on two consecutive cycles → 16 bins on consecutive cycles, second frame's bin 0 immediately after first frame's `outLast`.
- Overflow: `outReady` = 0, three frames presented → the third gives `frameDropped` = 1 for one cycle; raising `outReady` then yields exactly frames 1 and 2.
- Reset mid-drain: assert `rst_n` = 0 after 3 bins → `outValid` = 0 and `busy` = 0 immediately; the next frame after release starts at idx 0.
- `FFT8_UNLOAD_MAG_EN`:
  - bin -4 + j4 → `outMag` = 16'h0600;
  - bin 16'h7F00 + j16'h7F00 → `outMag` saturates to 16'h7FFF.
